// File: rtl/adpll_lock_ctrl_if.sv
// Control/status bundle between the ADPLL lock controller and its
// phase detector / NCO. The bench or a parent block drives the master side,
// and the controller is the slave.
//
// Handshake: there is no ready. err_valid is a single-cycle strobe that
// qualifies ctrl/ctrl_sign on that clock edge only. start is a one-cycle
// pulse and stop is a level. All status outputs are registered.
interface adpll_lock_ctrl_if;
    logic       start;
    logic       stop;
    logic       err_valid;
    logic       ctrl_sign;
    logic [4:0] ctrl;
    logic [4:0] knco;
    logic [4:0] thresh_val;
    logic [4:0] nco_offset;
    logic       loop_en;
    logic       locked;
    logic       fail;
    logic [1:0] state;

    modport master (
        output start, stop, err_valid, ctrl_sign, ctrl,
        input  knco, thresh_val, nco_offset, loop_en, locked, fail, state
    );

    modport slave (
        input  start, stop, err_valid, ctrl_sign, ctrl,
        output knco, thresh_val, nco_offset, loop_en, locked, fail, state
    );
endinterface

// File: rtl/adpll_lock_ctrl.sv
// ADPLL lock controller. A coarse search steps the NCO base threshold until
// the phase error settles. A fine phase then enables the loop and counts
// in-tolerance samples up to lock. Lock is dropped after a run of bad
// samples, and an acquisition timeout restarts the coarse search.
module adpll_lock_ctrl #(
    parameter logic [4:0]  THRESH_INIT = 5'd16,
    parameter logic [4:0]  NCO_OFS     = 5'd4,
    parameter logic [4:0]  KNCO_TRK    = 5'd2,
    parameter logic [4:0]  LOCK_TOL    = 5'd1,
    parameter int          COARSE_GOOD = 4,
    parameter int          LOCK_CNT    = 16,
    parameter int          UNLOCK_CNT  = 4,
    parameter logic [15:0] TIMEOUT     = 16'd1000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    adpll_lock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // The sample counters share one width. 16 bits covers any sensible
    // lock or unlock run length.
    localparam logic [15:0] COARSE_GOOD_C = 16'(COARSE_GOOD);
    localparam logic [15:0] LOCK_CNT_C    = 16'(LOCK_CNT);
    localparam logic [15:0] UNLOCK_CNT_C  = 16'(UNLOCK_CNT);

    state_t      r_state;
    logic [4:0]  r_knco;
    logic [4:0]  r_thresh;
    logic        r_loop_en;
    logic        r_locked;
    logic        r_fail;
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;
    logic [15:0] r_tmo_cnt;

    logic        w_in_tol;
    logic        w_acquiring;
    logic        w_tmo_hit;
    logic [15:0] w_good_inc;
    logic [15:0] w_bad_inc;
    logic [15:0] w_tmo_inc;
    logic [4:0]  w_thresh_up;
    logic [4:0]  w_thresh_dn;

    // The tolerance test uses only the error magnitude. The sign matters
    // only for the coarse step direction.
    assign w_in_tol    = (bus.ctrl <= LOCK_TOL);
    assign w_acquiring = (r_state == ST_COARSE) || (r_state == ST_FINE);

    // Saturating increments, so that no counter can wrap back to zero.
    assign w_good_inc = (r_good_cnt == 16'hFFFF) ? r_good_cnt : r_good_cnt + 16'd1;
    assign w_bad_inc  = (r_bad_cnt  == 16'hFFFF) ? r_bad_cnt  : r_bad_cnt  + 16'd1;
    assign w_tmo_inc  = (r_tmo_cnt  == 16'hFFFF) ? r_tmo_cnt  : r_tmo_cnt  + 16'd1;

    // The timeout fires on the sample that would bring the count to TIMEOUT.
    assign w_tmo_hit = (w_tmo_inc >= TIMEOUT);

    // The coarse threshold moves within 1..31. It never reaches 0, so the
    // NCO always keeps a usable base period.
    assign w_thresh_up = (r_thresh >= 5'd31) ? 5'd31 : r_thresh + 5'd1;
    assign w_thresh_dn = (r_thresh <= 5'd1)  ? 5'd1  : r_thresh - 5'd1;

    // Lock FSM. All outputs are registered in this block.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_knco     <= 5'd0;
            r_thresh   <= THRESH_INIT;
            r_loop_en  <= 1'b0;
            r_locked   <= 1'b0;
            r_fail     <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_fail <= 1'b0;
            if (bus.stop) begin
                // stop wins over everything else, including the timeout.
                r_state    <= ST_IDLE;
                r_knco     <= 5'd0;
                r_thresh   <= THRESH_INIT;
                r_loop_en  <= 1'b0;
                r_locked   <= 1'b0;
                r_good_cnt <= '0;
                r_bad_cnt  <= '0;
                r_tmo_cnt  <= '0;
            end else if (bus.err_valid && w_acquiring && w_tmo_hit) begin
                // Acquisition took too long, so restart the coarse search from scratch.
                r_state    <= ST_COARSE;
                r_fail     <= 1'b1;
                r_knco     <= 5'd0;
                r_thresh   <= THRESH_INIT;
                r_loop_en  <= 1'b0;
                r_locked   <= 1'b0;
                r_good_cnt <= '0;
                r_bad_cnt  <= '0;
                r_tmo_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_state    <= ST_COARSE;
                            r_thresh   <= THRESH_INIT;
                            r_good_cnt <= '0;
                            r_tmo_cnt  <= '0;
                        end
                    end
                    ST_COARSE: begin
                        if (bus.err_valid) begin
                            r_tmo_cnt <= w_tmo_inc;
                            if (w_in_tol) begin
                                if (w_good_inc >= COARSE_GOOD_C) begin
                                    r_state    <= ST_FINE;
                                    r_knco     <= KNCO_TRK;
                                    r_loop_en  <= 1'b1;
                                    r_good_cnt <= '0;
                                end else begin
                                    r_good_cnt <= w_good_inc;
                                end
                            end else begin
                                // A leading NCO needs a longer period, so raise the threshold.
                                r_thresh   <= bus.ctrl_sign ? w_thresh_up : w_thresh_dn;
                                r_good_cnt <= '0;
                            end
                        end
                    end
                    ST_FINE: begin
                        if (bus.err_valid) begin
                            if (w_in_tol) begin
                                if (w_good_inc >= LOCK_CNT_C) begin
                                    r_state    <= ST_LOCKED;
                                    r_locked   <= 1'b1;
                                    r_good_cnt <= '0;
                                    r_bad_cnt  <= '0;
                                    r_tmo_cnt  <= '0;
                                end else begin
                                    r_good_cnt <= w_good_inc;
                                    r_tmo_cnt  <= w_tmo_inc;
                                end
                            end else begin
                                r_good_cnt <= '0;
                                r_tmo_cnt  <= w_tmo_inc;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (bus.err_valid) begin
                            if (w_in_tol) begin
                                r_bad_cnt <= '0;
                            end else if (w_bad_inc >= UNLOCK_CNT_C) begin
                                r_state    <= ST_FINE;
                                r_locked   <= 1'b0;
                                r_good_cnt <= '0;
                                r_bad_cnt  <= '0;
                            end else begin
                                r_bad_cnt <= w_bad_inc;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.knco       = r_knco;
    assign bus.thresh_val = r_thresh;
    assign bus.nco_offset = NCO_OFS;
    assign bus.loop_en    = r_loop_en;
    assign bus.locked     = r_locked;
    assign bus.fail       = r_fail;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Bench for adpll_lock_ctrl. It applies a table of single-cycle vectors,
// followed by hand-written multi-cycle sequences. u_dut uses the default
// parameters. u_dut_tmo uses TIMEOUT=10, mirrors the same inputs, and is
// checked only in the timeout section.
module tb_adpll_lock_ctrl;

    logic clk;
    logic rst;

    adpll_lock_ctrl_if bus();
    adpll_lock_ctrl_if bus2();

    adpll_lock_ctrl u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    adpll_lock_ctrl #(.TIMEOUT(16'd10)) u_dut_tmo (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus2)
    );

    assign bus2.start     = bus.start;
    assign bus2.stop      = bus.stop;
    assign bus2.err_valid = bus.err_valid;
    assign bus2.ctrl_sign = bus.ctrl_sign;
    assign bus2.ctrl      = bus.ctrl;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Observed word: {state, knco, thresh_val, loop_en, locked, fail}
    logic [14:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          failures;

    function automatic logic [14:0] pk(input logic [1:0] s, input logic [4:0] k,
                                       input logic [4:0] th, input logic le,
                                       input logic lk, input logic fl);
        return {s, k, th, le, lk, fl};
    endfunction

    function automatic logic [14:0] obs(input bit sel);
        if (sel)
            return {bus2.state, bus2.knco, bus2.thresh_val, bus2.loop_en, bus2.locked, bus2.fail};
        return {bus.state, bus.knco, bus.thresh_val, bus.loop_en, bus.locked, bus.fail};
    endfunction

    task automatic sb_check(input bit sel);
        logic [14:0] got;
        logic [14:0] exp;
        string       nm;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = obs(sel);
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got st=%0d knco=%0d thr=%0d le=%b lk=%b fail=%b, exp st=%0d knco=%0d thr=%0d le=%b lk=%b fail=%b",
                     nm, got[14:13], got[12:8], got[7:3], got[2], got[1], got[0],
                     exp[14:13], exp[12:8], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_ofs(input string nm, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got nco_offset=%0d exp %0d", nm, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one clock cycle of inputs and queues the expected outputs. It
    // then compares just after the edge and returns the pulse inputs to 0.
    task automatic step(input logic st, input logic sp, input logic ev, input logic sg,
                        input logic [4:0] c, input logic [14:0] exp, input string nm,
                        input bit sel);
        bus.start     = st;
        bus.stop      = sp;
        bus.err_valid = ev;
        bus.ctrl_sign = sg;
        bus.ctrl      = c;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.err_valid = 1'b0;
        sb_check(sel);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       nm;
        logic        st;
        logic        sp;
        logic        ev;
        logic        sg;
        logic [4:0]  c;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[14];

    logic [14:0] idle_w;
    logic [14:0] fine_w;
    logic [14:0] lock_w;

    initial begin
        checks   = 0;
        failures = 0;
        idle_w = pk(2'd0, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0);
        fine_w = pk(2'd2, 5'd2, 5'd16, 1'b1, 1'b0, 1'b0);
        lock_w = pk(2'd3, 5'd2, 5'd16, 1'b1, 1'b1, 1'b0);

        vecs[0]  = '{"idle_ignores_ev", 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, idle_w};
        vecs[1]  = '{"start_with_stop", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, idle_w};
        vecs[2]  = '{"start",           1'b1, 1'b0, 1'b0, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[3]  = '{"start_in_coarse", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[4]  = '{"coarse_good1",    1'b0, 1'b0, 1'b1, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[5]  = '{"coarse_no_ev",    1'b0, 1'b0, 1'b0, 1'b1, 5'd9, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[6]  = '{"coarse_tol_edge", 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[7]  = '{"coarse_good3",    1'b0, 1'b0, 1'b1, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[8]  = '{"coarse_step_up",  1'b0, 1'b0, 1'b1, 1'b1, 5'd2, pk(2'd1, 5'd0, 5'd17, 1'b0, 1'b0, 1'b0)};
        vecs[9]  = '{"coarse_step_dn",  1'b0, 1'b0, 1'b1, 1'b0, 5'd2, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[10] = '{"coarse_regood1",  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[11] = '{"coarse_regood2",  1'b0, 1'b0, 1'b1, 1'b1, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[12] = '{"coarse_regood3",  1'b0, 1'b0, 1'b1, 1'b0, 5'd1, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0)};
        vecs[13] = '{"coarse_to_fine",  1'b0, 1'b0, 1'b1, 1'b1, 5'd0, fine_w};

        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.err_valid = 1'b0;
        bus.ctrl_sign = 1'b0;
        bus.ctrl      = 5'd0;

        // Reset values while reset is held
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(idle_w);
        name_q.push_back("reset_state");
        sb_check(1'b0);
        check_ofs("reset_nco_offset", bus.nco_offset, 5'd4);
        rst = 1'b0;

        // Table-driven vectors: idle, start/stop, coarse stepping, coarse->fine
        for (int i = 0; i < 14; i++)
            step(vecs[i].st, vecs[i].sp, vecs[i].ev, vecs[i].sg, vecs[i].c, vecs[i].exp, vecs[i].nm, 1'b0);

        // FINE: 15 good, 1 bad, 15 good stay FINE; the 16th good locks
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 1'b1, 1'(i & 1), 5'd0, fine_w, "fine_good", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, fine_w, "fine_bad_clears", 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, fine_w, "fine_no_ev", 1'b0);
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 1'b1, 1'(i & 1), 5'd1, fine_w, "fine_regood", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, lock_w, "fine_to_locked", 1'b0);

        // LOCKED: 3 bad, 1 good, 3 bad hold lock; the 4th bad drops to FINE
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, lock_w, "locked_bad", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd1, lock_w, "locked_good_clears", 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, lock_w, "locked_rebad", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, fine_w, "unlock_to_fine", 1'b0);

        // Re-lock from FINE (counters were cleared), then stop in LOCKED
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, fine_w, "relock_good", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, lock_w, "relock", 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, idle_w, "stop_in_locked", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, idle_w, "idle_after_stop", 1'b0);

        // COARSE saturation: 20 up-steps stop at 31, then 40 down-steps stop at 1
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0), "start2", 1'b0);
        for (int i = 1; i <= 20; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 5'd5,
                 pk(2'd1, 5'd0, 5'((16 + i > 31) ? 31 : 16 + i), 1'b0, 1'b0, 1'b0), "coarse_sat_up", 1'b0);
        for (int i = 1; i <= 40; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'd5,
                 pk(2'd1, 5'd0, 5'((31 - i < 1) ? 1 : 31 - i), 1'b0, 1'b0, 1'b0), "coarse_sat_dn", 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, idle_w, "stop_in_coarse", 1'b0);

        // Asynchronous reset during acquisition
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0), "start3", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, pk(2'd1, 5'd0, 5'd17, 1'b0, 1'b0, 1'b0), "pre_reset_up1", 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, pk(2'd1, 5'd0, 5'd18, 1'b0, 1'b0, 1'b0), "pre_reset_up2", 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(idle_w);
        name_q.push_back("async_reset_immediate");
        sb_check(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, idle_w, "idle_after_reset", 1'b0);

        // Timeout (u_dut_tmo, TIMEOUT=10): the 10th sample pulses fail
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0), "tmo_start", 1'b1);
        for (int i = 1; i <= 9; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9,
                 pk(2'd1, 5'd0, 5'(16 + i), 1'b0, 1'b0, 1'b0), "tmo_count", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b1), "tmo_fail_pulse", 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0), "tmo_fail_clears", 1'b1);

        // Timeout beats COARSE->FINE on the same sample: 6 bad, then 4 good
        for (int i = 1; i <= 6; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 5'd9,
                 pk(2'd1, 5'd0, 5'(16 + i), 1'b0, 1'b0, 1'b0), "tmo2_bad", 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,
                 pk(2'd1, 5'd0, 5'd22, 1'b0, 1'b0, 1'b0), "tmo2_good", 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, pk(2'd1, 5'd0, 5'd16, 1'b0, 1'b0, 1'b1), "tmo_over_fine", 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, idle_w, "tmo_stop", 1'b1);
        check_ofs("final_nco_offset", bus2.nco_offset, 5'd4);

        // ---------------- final report ----------------
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries, exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adpll_lock_ctrl.md
ADPLL_LOCK_CTRL -- requirements
Module: adpll_lock_ctrl

Interface
REQ-001 Parameter THRESH_INIT, default 5'd16, meaning the NCO threshold loaded on entry to IDLE or COARSE.
REQ-002 Parameter NCO_OFS, default 5'd4, meaning the constant nco_offset driven to the NCO.
REQ-003 Parameter KNCO_TRK, default 5'd2, meaning the NCO gain used in FINE and LOCKED.
REQ-004 Parameter LOCK_TOL, default 5'd1, meaning the largest |error| that counts as in-tolerance.
REQ-005 Parameter COARSE_GOOD, default 4, meaning the consecutive in-tolerance samples needed to leave COARSE.
REQ-006 Parameter LOCK_CNT, default 16, meaning the consecutive in-tolerance samples needed to reach LOCKED.
REQ-007 Parameter UNLOCK_CNT, default 4, meaning the consecutive out-of-tolerance samples needed to drop lock.
REQ-008 Parameter TIMEOUT, default 16'd1000, meaning the maximum number of err_valid samples allowed in COARSE plus FINE.
REQ-009 clk  in  1  system clock; all logic is on the rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 start  in  1  single-cycle pulse that begins acquisition.
REQ-012 stop  in  1  level input that forces the block to IDLE.
REQ-013 err_valid  in  1  single-cycle strobe, one per reference period.
REQ-014 ctrl_sign  in  1  error sign: 1 = NCO leading (slow it down), 0 = NCO lagging.
REQ-015 ctrl  in  5  error magnitude, unsigned.
REQ-016 knco  out  5  NCO gain.
REQ-017 thresh_val  out  5  NCO base threshold.
REQ-018 nco_offset  out  5  NCO offset.
REQ-019 loop_en  out  1  closed-loop enable.
REQ-020 locked  out  1  lock indicator.
REQ-021 fail  out  1  single-cycle acquisition-timeout pulse.
REQ-022 state  out  2  current state: 0 IDLE, 1 COARSE, 2 FINE, 3 LOCKED.

Function
REQ-023 All outputs shall be registered, so each change is visible on the cycle after the clk edge that causes it.
REQ-024 nco_offset shall equal NCO_OFS at all times, including during reset.
REQ-025 Define "in-tol" as ctrl <= LOCK_TOL; this comparison ignores ctrl_sign.
REQ-026 The counters, the state and the outputs shall change only on clk edges where err_valid=1, except for the transitions caused by start, stop and reset.
REQ-027 IDLE: knco=0, loop_en=0, locked=0, thresh_val=THRESH_INIT; start=1 with stop=0 -> COARSE, clearing the good counter and the timeout counter.
REQ-028 COARSE: knco=0, loop_en=0; on an err_valid sample that is not in-tol, thresh_val shall step +1 if ctrl_sign=1 and -1 if ctrl_sign=0, saturating at 1 and 31, and the good counter shall clear.
REQ-029 COARSE: on an in-tol sample, thresh_val shall hold and the good counter shall increment; when the counter reaches COARSE_GOOD -> FINE, with knco=KNCO_TRK and loop_en=1 in the same update, and the counter shall clear.
REQ-030 FINE: thresh_val shall hold; an in-tol sample shall increment the good counter and a not-in-tol sample shall clear it; when the counter reaches LOCK_CNT -> LOCKED with locked=1.
REQ-031 LOCKED: consecutive not-in-tol samples shall increment the bad counter and an in-tol sample shall clear it; when the counter reaches UNLOCK_CNT -> FINE with locked=0 and both counters cleared; knco, loop_en and thresh_val shall hold.
REQ-032 The timeout counter shall increment on every err_valid sample taken in COARSE or FINE and shall clear on entry to LOCKED or IDLE.
REQ-033 When the timeout counter reaches TIMEOUT, the block shall pulse fail=1 for one cycle and go to COARSE with thresh_val=THRESH_INIT, knco=0, loop_en=0 and all counters cleared.
REQ-034 stop=1 shall force IDLE on the next edge from any state and shall take priority over start, err_valid and the timeout.
REQ-035 A start pulse received outside IDLE shall be ignored.
REQ-036 Timeout shall take priority over a COARSE->FINE or FINE->LOCKED transition evaluated on the same sample.
REQ-037 All counters shall saturate and shall never wrap.

Reset
REQ-038 While reset=1: state=IDLE, knco=0, thresh_val=THRESH_INIT, nco_offset=NCO_OFS, loop_en=0, locked=0, fail=0, and all counters=0.
REQ-039 An assertion of reset in mid-acquisition shall abort immediately and asynchronously, and the block shall remain in IDLE after release until the next start.

Verification
REQ-040 Reset then start, with 4 samples of ctrl=0 -> state 1 then 2, knco=2, loop_en=1.
REQ-041 In COARSE, 20 samples of ctrl=5, ctrl_sign=1 -> thresh_val = 16+15 = 31, saturated, with no further increase.
REQ-042 In FINE, 15 in-tol samples, 1 sample of ctrl=3, then 16 in-tol samples -> locked=1 only after the final sample.
REQ-043 In LOCKED, 3 samples of ctrl=7, 1 in-tol sample, then 4 samples of ctrl=7 -> locked drops only after the fourth bad sample, state=2.
REQ-044 With TIMEOUT=10, 10 samples of ctrl=9 -> one fail pulse, state=1, thresh_val=16.
REQ-045 start and stop asserted together in IDLE -> stays IDLE; stop in LOCKED -> IDLE, knco=0, locked=0 on the next cycle.
